// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter and power-up initialiser for a 2R/1W register-file RAM.
// Sweeps every entry to INIT_VALUE after reset, then grants one dual-read or write per cycle.

module regfile_arbiter_rsp #(
    parameter int DW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data1,
    output logic [DW-1:0] rsp_data2
);
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else begin
            rsp_valid <= load;
            if (load) begin
                rsp_data1 <= rdata1;
                rsp_data2 <= rdata2;
            end
        end
    end
endmodule

module regfile_arbiter #(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter int INIT_VALUE = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c0_req_valid,
    output logic          c0_req_ready,
    input  logic          c0_req_we,
    input  logic [AW-1:0] c0_req_addr1,
    input  logic [AW-1:0] c0_req_addr2,
    input  logic [DW-1:0] c0_req_wdata,
    output logic          c0_rsp_valid,
    output logic [DW-1:0] c0_rsp_data1,
    output logic [DW-1:0] c0_rsp_data2,
    input  logic          c1_req_valid,
    output logic          c1_req_ready,
    input  logic          c1_req_we,
    input  logic [AW-1:0] c1_req_addr1,
    input  logic [AW-1:0] c1_req_addr2,
    input  logic [DW-1:0] c1_req_wdata,
    output logic          c1_rsp_valid,
    output logic [DW-1:0] c1_rsp_data1,
    output logic [DW-1:0] c1_rsp_data2,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr1,
    output logic [AW-1:0] ram_raddr2,
    input  logic [DW-1:0] ram_rdata1,
    input  logic [DW-1:0] ram_rdata2,
    output logic          init_done
);
    localparam logic [DW-1:0] INIT_W = DW'(INIT_VALUE);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_nx;
    logic [AW-1:0]          init_cnt;
    logic                   prio;
    logic [1:0]             gnt;
    logic                   sel;
    logic [1:0]             req_valid, req_we, rd_load;
    logic [1:0][AW-1:0]     req_addr1, req_addr2;
    logic [1:0][DW-1:0]     req_wdata;
    logic [1:0]             rsp_valid;
    logic [1:0][DW-1:0]     rsp_data1, rsp_data2;

    assign req_valid = {c1_req_valid, c0_req_valid};
    assign req_we    = {c1_req_we,    c0_req_we};
    assign req_addr1 = {c1_req_addr1, c0_req_addr1};
    assign req_addr2 = {c1_req_addr2, c0_req_addr2};
    assign req_wdata = {c1_req_wdata, c0_req_wdata};

    // Grant is combinational on valid; prio only breaks ties.
    always_comb begin
        gnt = 2'b00;
        if (state == RUN) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign sel          = gnt[1];
    assign rd_load      = gnt & ~req_we;
    assign c0_req_ready = gnt[0];
    assign c1_req_ready = gnt[1];

    always_comb begin
        state_nx   = state;
        ram_w_en   = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        ram_raddr1 = '0;
        ram_raddr2 = '0;
        if (state == INIT) begin
            ram_w_en  = 1'b1;
            ram_waddr = init_cnt;
            ram_wdata = INIT_W;
            if (init_cnt == '1) state_nx = RUN;
        end else if (|gnt) begin
            if (req_we[sel]) begin
                ram_w_en  = 1'b1;
                ram_waddr = req_addr1[sel];
                ram_wdata = req_wdata[sel];
            end else begin
                ram_raddr1 = req_addr1[sel];
                ram_raddr2 = req_addr2[sel];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            prio      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            init_done <= (state_nx == RUN);
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (|gnt) prio <= gnt[0];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        regfile_arbiter_rsp #(.DW(DW)) u_rsp (
            .clock     (clock),
            .reset     (reset),
            .load      (rd_load[i]),
            .rdata1    (ram_rdata1),
            .rdata2    (ram_rdata2),
            .rsp_valid (rsp_valid[i]),
            .rsp_data1 (rsp_data1[i]),
            .rsp_data2 (rsp_data2[i])
        );
    end

    assign c0_rsp_valid = rsp_valid[0];
    assign c0_rsp_data1 = rsp_data1[0];
    assign c0_rsp_data2 = rsp_data2[0];
    assign c1_rsp_valid = rsp_valid[1];
    assign c1_rsp_data1 = rsp_data1[1];
    assign c1_rsp_data2 = rsp_data2[1];
endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: per-cycle expectations from a reference model
// feed a queue that an independent monitor drains and compares.

module tb_regfile_arbiter;
    localparam logic [3:0] INIT = 4'h0;

    logic       clock = 1'b0;
    logic       reset;
    logic       c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid;
    logic [3:0] c0_req_addr1, c0_req_addr2, c0_req_wdata, c0_rsp_data1, c0_rsp_data2;
    logic       c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid;
    logic [3:0] c1_req_addr1, c1_req_addr2, c1_req_wdata, c1_rsp_data1, c1_rsp_data2;
    logic       ram_w_en, init_done;
    logic [3:0] ram_waddr, ram_wdata, ram_raddr1, ram_raddr2, ram_rdata1, ram_rdata2;

    always #5 clock = ~clock;

    regfile_arbiter #(.AW(4), .DW(4), .INIT_VALUE(0)) dut (
        .clock(clock), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
        .c0_req_addr1(c0_req_addr1), .c0_req_addr2(c0_req_addr2), .c0_req_wdata(c0_req_wdata),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data1(c0_rsp_data1), .c0_rsp_data2(c0_rsp_data2),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
        .c1_req_addr1(c1_req_addr1), .c1_req_addr2(c1_req_addr2), .c1_req_wdata(c1_req_wdata),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data1(c1_rsp_data1), .c1_rsp_data2(c1_rsp_data2),
        .ram_w_en(ram_w_en), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr1(ram_raddr1), .ram_raddr2(ram_raddr2),
        .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2), .init_done(init_done)
    );

    // The RAM itself: combinational reads, clocked write, no reset.
    logic [3:0] ram [16];
    always_ff @(posedge clock) if (ram_w_en) ram[ram_waddr] <= ram_wdata;
    assign ram_rdata1 = ram[ram_raddr1];
    assign ram_rdata2 = ram[ram_raddr2];

    typedef struct packed {
        logic       v, we;
        logic [3:0] a1, a2, wd;
    } req_t;

    typedef struct {
        bit       chk, r0, r1, v0, v1, done, wen;
        bit [3:0] d0a, d0b, d1a, d1b, wa, wd, ra1, ra2;
    } exp_t;

    exp_t q[$];

    // Reference model: what the arbiter should look like, in plain terms.
    bit       m_known = 0, m_run = 0, m_prio = 0, m_done = 0;
    int       m_cnt = 0;
    bit       m_rv [2];
    bit [3:0] m_rd1 [2], m_rd2 [2];
    bit [3:0] m_mem [16];

    int n_cmp = 0, n_bad = 0;

    localparam req_t IDLE = '0;

    function automatic req_t rd(input int a1, input int a2);
        req_t r = '0;
        r.v = 1; r.a1 = a1[3:0]; r.a2 = a2[3:0];
        return r;
    endfunction

    function automatic req_t wr(input int a, input int d);
        req_t r = '0;
        r.v = 1; r.we = 1; r.a1 = a[3:0]; r.wd = d[3:0];
        return r;
    endfunction

    function automatic req_t rnd();
        req_t r;
        r.v  = ($urandom_range(0, 99) < 60);
        r.we = ($urandom_range(0, 2) == 0);
        r.a1 = 4'($urandom_range(0, 15));
        r.a2 = 4'($urandom_range(0, 15));
        r.wd = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic cyc(input bit rst, input req_t r0, input req_t r1);
        exp_t e;
        req_t r [2];
        int   g;
        @(negedge clock);
        reset = rst;
        c0_req_valid = r0.v; c0_req_we = r0.we; c0_req_addr1 = r0.a1; c0_req_addr2 = r0.a2; c0_req_wdata = r0.wd;
        c1_req_valid = r1.v; c1_req_we = r1.we; c1_req_addr1 = r1.a1; c1_req_addr2 = r1.a2; c1_req_wdata = r1.wd;
        r[0] = r0; r[1] = r1;
        e = '{default: 0};
        e.chk = m_known; e.done = m_done;
        e.v0 = m_rv[0]; e.d0a = m_rd1[0]; e.d0b = m_rd2[0];
        e.v1 = m_rv[1]; e.d1a = m_rd1[1]; e.d1b = m_rd2[1];
        g = -1;
        if (!m_run) begin
            e.wen = 1; e.wa = 4'(m_cnt); e.wd = INIT;
        end else begin
            if (r0.v && r1.v) g = m_prio ? 1 : 0;
            else if (r0.v) g = 0;
            else if (r1.v) g = 1;
            if (g >= 0) begin
                if (r[g].we) begin e.wen = 1; e.wa = r[g].a1; e.wd = r[g].wd; end
                else begin e.ra1 = r[g].a1; e.ra2 = r[g].a2; end
            end
            e.r0 = (g == 0); e.r1 = (g == 1);
        end
        q.push_back(e);
        // Model state after the edge.
        if (rst) begin
            m_known = 1; m_run = 0; m_cnt = 0; m_prio = 0; m_done = 0;
            for (int i = 0; i < 2; i++) begin m_rv[i] = 0; m_rd1[i] = 0; m_rd2[i] = 0; end
        end else if (!m_run) begin
            if (m_cnt == 15) begin m_run = 1; m_done = 1; end
            m_cnt = (m_cnt + 1) % 16;
        end else begin
            m_rv[0] = 0; m_rv[1] = 0;
            if (g >= 0) begin
                if (!r[g].we) begin
                    m_rv[g] = 1; m_rd1[g] = m_mem[r[g].a1]; m_rd2[g] = m_mem[r[g].a2];
                end
                m_prio = (g == 0);
            end
        end
        if (e.wen) m_mem[e.wa] = e.wd;
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the stimulus has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("c0_ready", int'(c0_req_ready), int'(e.r0));
                    cmp("c1_ready", int'(c1_req_ready), int'(e.r1));
                    cmp("init_done", int'(init_done), int'(e.done));
                    cmp("ram_w_en", int'(ram_w_en), int'(e.wen));
                    cmp("ram_waddr", int'(ram_waddr), int'(e.wa));
                    cmp("ram_wdata", int'(ram_wdata), int'(e.wd));
                    cmp("ram_raddr1", int'(ram_raddr1), int'(e.ra1));
                    cmp("ram_raddr2", int'(ram_raddr2), int'(e.ra2));
                    cmp("c0_rsp_valid", int'(c0_rsp_valid), int'(e.v0));
                    cmp("c1_rsp_valid", int'(c1_rsp_valid), int'(e.v1));
                    cmp("c0_rsp_data1", int'(c0_rsp_data1), int'(e.d0a));
                    cmp("c0_rsp_data2", int'(c0_rsp_data2), int'(e.d0b));
                    cmp("c1_rsp_data1", int'(c1_rsp_data1), int'(e.d1a));
                    cmp("c1_rsp_data2", int'(c1_rsp_data2), int'(e.d1b));
                end
            end
        end
    end

    initial begin
        req_t a, b;
        bit   rst;
        reset = 1'b1;
        c0_req_valid = 0; c0_req_we = 0; c0_req_addr1 = 0; c0_req_addr2 = 0; c0_req_wdata = 0;
        c1_req_valid = 0; c1_req_we = 0; c1_req_addr1 = 0; c1_req_addr2 = 0; c1_req_wdata = 0;
        // c0 write held from reset through the sweep; must land after it.
        cyc(1, wr(9, 6), IDLE);
        repeat (16) cyc(0, wr(9, 6), IDLE);
        cyc(0, wr(9, 6), IDLE);
        cyc(0, rd(5, 15), IDLE);
        cyc(0, wr(3, 10), IDLE);
        cyc(0, IDLE, rd(3, 4));
        cyc(0, IDLE, rd(9, 0));
        cyc(0, IDLE, IDLE);
        // Contention: strict alternation.
        repeat (6) cyc(0, rd(1, 2), rd(3, 9));
        cyc(0, IDLE, IDLE);
        repeat (3) cyc(0, IDLE, rd(9, 3));
        cyc(0, rd(3, 9), rd(4, 5));
        cyc(0, IDLE, IDLE);
        // Reset mid-RUN, then again mid-sweep at init_cnt = 7.
        cyc(1, IDLE, IDLE);
        repeat (7) cyc(0, IDLE, IDLE);
        cyc(1, IDLE, IDLE);
        repeat (16) cyc(0, IDLE, IDLE);
        cyc(0, rd(3, 9), rd(0, 15));
        cyc(0, IDLE, IDLE);
        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            a = rst ? IDLE : rnd();
            b = rst ? IDLE : rnd();
            cyc(rst, a, b);
        end
        for (int i = 0; i < 16; i++) cyc(0, rd(i, 15 - i), IDLE);
        cyc(0, IDLE, IDLE);
        repeat (2) @(negedge clock);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
